// File: rtl/sec_queue_pkg.sv
// Shared definitions for the domain-tagged queues: security domain
// encodings and the occupancy state encoding.
package sec_queue_pkg;

  localparam logic DOMAIN_NS = 1'b0;
  localparam logic DOMAIN_S  = 1'b1;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

endpackage

// File: rtl/sec_queue2_ctrl.sv
// Occupancy FSM for sec_queue2: ready/valid generation and the per-entry
// load / shift / clear enables, including domain-flush compaction.
module sec_queue2_ctrl
  import sec_queue_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enq_val,
  input  logic       deq_rdy,
  input  logic       flush_val,
  input  logic       flush_domain,
  input  logic       dom0,
  input  logic       dom1,
  output logic       enq_rdy,
  output logic       deq_val,
  output logic [1:0] count,
  output logic       load0,
  output logic       load1,
  output logic       shift,
  output logic       clr0,
  output logic       clr1
);

  q_state_t state, state_n;
  logic     enq_fire, deq_fire, kill0, kill1;

  assign enq_rdy  = (state != Q_FULL) && !flush_val;
  assign deq_val  = (state != Q_EMPTY) && !flush_val;
  assign count    = 2'(state);
  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  // A valid entry is killed by a flush when its domain matches.
  assign kill0 = flush_val && (state != Q_EMPTY) && (dom0 == flush_domain);
  assign kill1 = flush_val && (state == Q_FULL)  && (dom1 == flush_domain);

  always_ff @(posedge clk) begin
    if (!reset) state <= Q_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load0   = 1'b0;
    load1   = 1'b0;
    shift   = 1'b0;
    clr0    = 1'b0;
    clr1    = 1'b0;
    if (flush_val) begin
      if (kill0 && kill1) begin
        clr0    = 1'b1;
        clr1    = 1'b1;
        state_n = Q_EMPTY;
      end else if (kill0 && state == Q_FULL) begin
        shift   = 1'b1;
        clr1    = 1'b1;
        state_n = Q_ONE;
      end else if (kill0) begin
        clr0    = 1'b1;
        state_n = Q_EMPTY;
      end else if (kill1) begin
        clr1    = 1'b1;
        state_n = Q_ONE;
      end
    end else begin
      unique case (state)
        Q_EMPTY: if (enq_fire) begin
          load0   = 1'b1;
          state_n = Q_ONE;
        end
        Q_ONE: begin
          if (enq_fire && deq_fire) begin
            load0 = 1'b1;
          end else if (enq_fire) begin
            load1   = 1'b1;
            state_n = Q_FULL;
          end else if (deq_fire) begin
            clr0    = 1'b1;
            state_n = Q_EMPTY;
          end
        end
        Q_FULL: if (deq_fire) begin
          shift   = 1'b1;
          clr1    = 1'b1;
          state_n = Q_ONE;
        end
        default: state_n = Q_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/sec_queue2.sv
// Two-entry domain-tagged valid/ready queue with single-cycle domain flush;
// freed entries and the empty-queue outputs are always scrubbed to zero.
module sec_queue2
  import sec_queue_pkg::*;
#(
  parameter int P_NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic               enq_domain,
  input  logic [P_NBITS-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic               deq_domain,
  output logic [P_NBITS-1:0] deq_msg,
  input  logic               flush_val,
  input  logic               flush_domain,
  output logic [1:0]         count
);

  logic [P_NBITS-1:0] ent0_msg, ent1_msg;
  logic               ent0_dom, ent1_dom;
  logic               load0, load1, shift, clr0, clr1;

  sec_queue2_ctrl u_ctrl (
    .clk          (clk),
    .reset        (reset),
    .enq_val      (enq_val),
    .deq_rdy      (deq_rdy),
    .flush_val    (flush_val),
    .flush_domain (flush_domain),
    .dom0         (ent0_dom),
    .dom1         (ent1_dom),
    .enq_rdy      (enq_rdy),
    .deq_val      (deq_val),
    .count        (count),
    .load0        (load0),
    .load1        (load1),
    .shift        (shift),
    .clr0         (clr0),
    .clr1         (clr1)
  );

  // Storage is zeroed on reset too, so nothing of a previous world survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent0_msg <= '0;
      ent0_dom <= DOMAIN_NS;
      ent1_msg <= '0;
      ent1_dom <= DOMAIN_NS;
    end else begin
      if (load0) begin
        ent0_msg <= enq_msg;
        ent0_dom <= enq_domain;
      end else if (shift) begin
        ent0_msg <= ent1_msg;
        ent0_dom <= ent1_dom;
      end else if (clr0) begin
        ent0_msg <= '0;
        ent0_dom <= DOMAIN_NS;
      end
      if (load1) begin
        ent1_msg <= enq_msg;
        ent1_dom <= enq_domain;
      end else if (clr1) begin
        ent1_msg <= '0;
        ent1_dom <= DOMAIN_NS;
      end
    end
  end

  assign deq_msg    = (count != 2'(Q_EMPTY)) ? ent0_msg : '0;
  assign deq_domain = (count != 2'(Q_EMPTY)) ? ent0_dom : DOMAIN_NS;

endmodule

// File: doc/sec_queue2.md
# sec_queue2

Two-entry, domain-tagged valid/ready queue that feeds the datapath's enable/reset pipeline registers. Each entry carries a one-bit security domain alongside its payload. The payload is labelled by that domain, and the downstream register stage takes `deq_domain` as its `domain` input. The queue adds a domain flush that scrubs every entry of a given domain in one cycle, so stale payload never survives a world switch.

## Interface
Parameters:
- `P_NBITS`, default 32: payload width.

Ports (clock and reset first):
- `clk`, in, 1: clock, label `{L}`.
- `reset`, in, 1: reset, synchronous, active-low; clock `clk`. Label `{L}`.
- `enq_val`, in, 1: enqueue request, label `{Ctrl enq_domain}`.
- `enq_rdy`, out, 1: queue can accept, label `{L}`.
- `enq_domain`, in, 1: domain of the incoming message, label `{L}`; 0 = normal, 1 = secure.
- `enq_msg`, in, `P_NBITS`: payload, label `{Data enq_domain}`.
- `deq_val`, out, 1: head entry valid, label `{Ctrl deq_domain}`.
- `deq_rdy`, in, 1: consumer accepts the head, label `{Ctrl deq_domain}`.
- `deq_domain`, out, 1: domain of the head entry, label `{L}`.
- `deq_msg`, out, `P_NBITS`: head payload, label `{Data deq_domain}`.
- `flush_val`, in, 1: flush request, label `{L}`.
- `flush_domain`, in, 1: domain whose entries are flushed, label `{L}`.
- `count`, out, 2: occupancy 0–2, label `{L}`.

## Operation
- **Storage:** two entries, each `{valid, domain, msg}`. Storage is ordered: entry 0 is always the head, and entry 1 is valid only if entry 0 is valid.
- **FSM states:** EMPTY (count 0), ONE (count 1), FULL (count 2).
- **Enqueue fire:** `enq_val && enq_rdy`, where `enq_rdy = !FULL && !flush_val`. There is no bypass: when FULL, `enq_rdy` stays 0 even if `deq_rdy` = 1.
- **Dequeue fire:** `deq_val && deq_rdy`, where `deq_val = !EMPTY && !flush_val`.
- **Transitions:**
  - EMPTY + enq → ONE.
  - ONE + enq only → FULL.
  - ONE + deq only → EMPTY.
  - ONE + enq + deq → ONE; the new message becomes the head.
  - FULL + deq → ONE; entry 1 shifts into entry 0.
- **Flush:**
  - When `flush_val` = 1, every valid entry whose domain equals `flush_domain` is invalidated and its msg and domain are zeroed.
  - A surviving entry 1 compacts into entry 0.
  - Enqueue and dequeue cannot fire in the same cycle, because both ready and valid are gated by `flush_val`.
- **Scrubbing:**
  - Any entry freed by dequeue or flush has msg and domain written to 0 in that cycle.
  - `deq_msg` and `deq_domain` are 0 whenever the queue is EMPTY.
- **Reset** (`reset` = 0 at a posedge): state goes to EMPTY and all storage is zeroed. Resulting outputs: `count` = 0, `deq_val` = 0, `deq_msg` = 0, `deq_domain` = 0, `enq_rdy` = 1.
  - Reset overrides any concurrent enqueue, dequeue or flush.
  - An entry mid-flight is discarded.

## Timing
- Enqueue to visibility: 1 cycle. A message accepted at edge N appears on `deq_*` after edge N.
- Throughput: one enqueue and one dequeue per cycle in state ONE. In state FULL, only dequeue can fire that cycle.
- `enq_rdy`, `deq_val`, `deq_msg`, `deq_domain` and `count` are functions of registered state plus the combinational `flush_val` gating only. There are no combinational paths from `enq_*` or `deq_rdy` to any output.
- A flush completes in one cycle. Occupancy after a flush is visible on `count` the next cycle.

## Structure
- **Shared package `sec_queue_pkg`:**
  - Domain constants `DOMAIN_NS` = 1'b0 and `DOMAIN_S` = 1'b1.
  - State encodings `Q_EMPTY` = 2'd0, `Q_ONE` = 2'd1, `Q_FULL` = 2'd2.
- **Sub-module `sec_queue2_ctrl`:** FSM, ready/valid generation, and per-entry load, shift and clear enables.
- **Top level:** two entry registers with their muxes (load from `enq_msg`, shift from entry 1, clear to 0), plus the output scrub logic.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `enq_val` = 1, `enq_msg` = 0xDEADBEEF, then release. Required: `count` = 0, `deq_val` = 0, `deq_msg` = 0, `enq_rdy` = 1 throughout.
- **Fill and order:**
  - Enqueue 0x11 (domain 0), then 0x22 (domain 1), with `deq_rdy` = 0. Required: `count` = 2, `enq_rdy` = 0, head = 0x11 / domain 0.
  - Then set `deq_rdy` = 1. Required: head becomes 0x22 / domain 1, then the queue goes EMPTY with `deq_msg` = 0.
- **Simultaneous enqueue and dequeue in ONE:** queue holds 0xA; enqueue 0xB with `deq_rdy` = 1. Required: `count` stays 1 and the head becomes 0xB next cycle.
- **Flush with compaction:** FULL with {0x5 domain 1, 0x6 domain 0}; pulse `flush_val` with `flush_domain` = 1. Required:
  - During the pulse cycle, `deq_val` = 0 and `enq_rdy` = 0, even with `enq_val` = 1 and `deq_rdy` = 1.
  - After the pulse: `count` = 1, head = 0x6 / domain 0, and entry 1 storage reads 0.
- **Flush of all entries:** FULL, both entries domain 0; flush domain 0. Required: EMPTY, `deq_msg` = 0, `deq_domain` = 0.
- **Reset mid-operation:** FULL, and `reset` = 0 in the same cycle as a dequeue fire and `enq_val` = 1. Required: EMPTY next cycle with all storage zeroed.
